// File: rtl/types_pkg.sv
// Shared types for the reorder buffer: entry layout and default register index width.
package types_pkg;

  localparam int PREG_W_DEFAULT = 7;

  typedef struct packed {
    logic [6:0]  pd_new;
    logic [6:0]  pd_old;
    logic [31:0] pc;
    logic        complete;
    logic        valid;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, complete out of order, commit one per cycle
// from head, and truncate on a branch flush.
module reorder_buffer
  import types_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int PREG_W = PREG_W_DEFAULT,
  parameter int N_CMPL = 3,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alloc_valid,
  output logic                    alloc_ready,
  input  logic [PREG_W-1:0]       alloc_pd_new,
  input  logic [PREG_W-1:0]       alloc_pd_old,
  input  logic [31:0]             alloc_pc,
  output logic [TAG_W-1:0]        alloc_tag,
  input  logic [N_CMPL-1:0]       cmpl_valid,
  input  logic [N_CMPL*TAG_W-1:0] cmpl_tag,
  input  logic                    flush_valid,
  input  logic [TAG_W-1:0]        flush_tag,
  output logic                    commit_valid,
  output logic [TAG_W-1:0]        commit_tag,
  output logic [PREG_W-1:0]       commit_pd_old,
  output logic [PREG_W-1:0]       commit_pd_new,
  output logic [31:0]             commit_pc,
  output logic [TAG_W:0]          count,
  output logic                    empty
);

  localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

  rob_entry_t       ent_q [DEPTH];
  rob_entry_t       ent_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic [DEPTH-1:0] hit;
  logic [DEPTH-1:0] younger;
  logic [TAG_W-1:0] flush_dist;
  logic             flush_ok;
  logic             alloc_fire;

  assign alloc_ready   = count_q < FULL_COUNT;
  assign alloc_tag     = tail_q;
  assign commit_valid  = ent_q[head_q].valid && ent_q[head_q].complete;
  assign commit_tag    = head_q;
  assign commit_pd_old = PREG_W'(ent_q[head_q].pd_old);
  assign commit_pd_new = PREG_W'(ent_q[head_q].pd_new);
  assign commit_pc     = ent_q[head_q].pc;
  assign count         = count_q;
  assign empty         = count_q == '0;

  assign flush_ok   = flush_valid && ent_q[flush_tag].valid;
  assign flush_dist = flush_tag - head_q;
  assign alloc_fire = alloc_valid && alloc_ready && !flush_valid;

  // Age is measured as distance from head, so "younger than flush_tag" survives wrap-around.
  always_comb begin
    hit     = '0;
    younger = '0;
    for (int i = 0; i < DEPTH; i++) begin
      younger[i] = flush_ok && ((TAG_W'(i) - head_q) > flush_dist);
      for (int p = 0; p < N_CMPL; p++) begin
        if (cmpl_valid[p] && (cmpl_tag[p*TAG_W +: TAG_W] == TAG_W'(i))) hit[i] = 1'b1;
      end
    end
  end

  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit[i] && ent_q[i].valid && !younger[i]) ent_d[i].complete = 1'b1;
      if (commit_valid && (head_q == TAG_W'(i))) begin
        ent_d[i].valid    = 1'b0;
        ent_d[i].complete = 1'b0;
      end
      if (younger[i]) begin
        ent_d[i].valid    = 1'b0;
        ent_d[i].complete = 1'b0;
      end
      if (alloc_fire && (tail_q == TAG_W'(i))) begin
        ent_d[i].pd_new   = 7'(alloc_pd_new);
        ent_d[i].pd_old   = 7'(alloc_pd_old);
        ent_d[i].pc       = alloc_pc;
        ent_d[i].complete = 1'b0;
        ent_d[i].valid    = 1'b1;
      end
    end
  end

  always_comb begin
    head_d = commit_valid ? head_q + TAG_W'(1) : head_q;
    if (flush_ok) begin
      tail_d  = flush_tag + TAG_W'(1);
      count_d = (TAG_W+1)'(flush_dist) + (TAG_W+1)'(1) - (TAG_W+1)'(commit_valid);
    end else begin
      tail_d  = alloc_fire ? tail_q + TAG_W'(1) : tail_q;
      count_d = count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Reorder buffer bench: directed scenarios plus random traffic against a queue-based model.
module tb_reorder_buffer;

  localparam int DEPTH  = 4;
  localparam int PREG_W = 7;
  localparam int N_CMPL = 3;
  localparam int TAG_W  = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    alloc_valid;
  logic                    alloc_ready;
  logic [PREG_W-1:0]       alloc_pd_new;
  logic [PREG_W-1:0]       alloc_pd_old;
  logic [31:0]             alloc_pc;
  logic [TAG_W-1:0]        alloc_tag;
  logic [N_CMPL-1:0]       cmpl_valid;
  logic [N_CMPL*TAG_W-1:0] cmpl_tag;
  logic                    flush_valid;
  logic [TAG_W-1:0]        flush_tag;
  logic                    commit_valid;
  logic [TAG_W-1:0]        commit_tag;
  logic [PREG_W-1:0]       commit_pd_old;
  logic [PREG_W-1:0]       commit_pd_new;
  logic [31:0]             commit_pc;
  logic [TAG_W:0]          count;
  logic                    empty;

  reorder_buffer #(.DEPTH(DEPTH), .PREG_W(PREG_W), .N_CMPL(N_CMPL)) dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_valid  (alloc_valid),
    .alloc_ready  (alloc_ready),
    .alloc_pd_new (alloc_pd_new),
    .alloc_pd_old (alloc_pd_old),
    .alloc_pc     (alloc_pc),
    .alloc_tag    (alloc_tag),
    .cmpl_valid   (cmpl_valid),
    .cmpl_tag     (cmpl_tag),
    .flush_valid  (flush_valid),
    .flush_tag    (flush_tag),
    .commit_valid (commit_valid),
    .commit_tag   (commit_tag),
    .commit_pd_old(commit_pd_old),
    .commit_pd_new(commit_pd_new),
    .commit_pc    (commit_pc),
    .count        (count),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [6:0]  pn;
    logic [6:0]  po;
    logic [31:0] pc;
    bit          done;
  } ent_t;

  ent_t q[$];          // live instructions, oldest first
  int   mtail = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    bit cv;
    cv = (q.size() > 0) && q[0].done;
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("alloc_ready", 32'(alloc_ready), 32'(q.size() < DEPTH));
    chk("alloc_tag", 32'(alloc_tag), 32'(mtail));
    chk("commit_valid", 32'(commit_valid), 32'(cv));
    if (cv) begin
      chk("commit_tag", 32'(commit_tag), 32'(q[0].tag));
      chk("commit_pd_old", 32'(commit_pd_old), 32'(q[0].po));
      chk("commit_pd_new", 32'(commit_pd_new), 32'(q[0].pn));
      chk("commit_pc", commit_pc, q[0].pc);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cyc(input bit av, input bit [2:0] cv, input bit [5:0] ct, input bit fv,
                     input bit [1:0] ft, input bit rst);
    ent_t e;
    int   sz0, k, tp;
    bit   cm;
    e.pn = 7'($urandom);
    e.po = 7'($urandom);
    e.pc = $urandom;
    e.done = 1'b0;
    reset = rst; alloc_valid = av; alloc_pd_new = e.pn; alloc_pd_old = e.po; alloc_pc = e.pc;
    cmpl_valid = cv; cmpl_tag = ct; flush_valid = fv; flush_tag = ft;
    if (rst) begin
      q.delete();
      mtail = 0;
    end else begin
      sz0 = q.size();
      cm  = (sz0 > 0) && q[0].done;
      k   = -1;
      if (fv) foreach (q[j]) if (q[j].tag == int'(ft)) k = j;
      for (int p = 0; p < N_CMPL; p++) begin
        tp = int'(ct[p*2 +: 2]);
        if (cv[p]) foreach (q[j]) if (q[j].tag == tp && !(k >= 0 && j > k)) q[j].done = 1'b1;
      end
      if (k >= 0) begin
        while (q.size() > k + 1) void'(q.pop_back());
        mtail = (int'(ft) + 1) % DEPTH;
      end
      if (cm) void'(q.pop_front());
      if (av && !fv && sz0 < DEPTH) begin
        e.tag = mtail;
        q.push_back(e);
        mtail = (mtail + 1) % DEPTH;
      end
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_model();
  endtask

  initial begin
    reset = 1'b1; alloc_valid = 0; alloc_pd_new = 0; alloc_pd_old = 0; alloc_pc = 0;
    cmpl_valid = 0; cmpl_tag = 0; flush_valid = 0; flush_tag = 0;

    // Reset state
    cyc(0, 0, 0, 0, 0, 1);
    chk("rst_ready", 32'(alloc_ready), 1);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_commit", 32'(commit_valid), 0);
    chk("rst_tag", 32'(alloc_tag), 0);

    // Fill to capacity, then a fifth request is refused
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0);
    chk("full_count", 32'(count), 4);
    chk("full_ready", 32'(alloc_ready), 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("full_refuse", 32'(count), 4);

    // Out-of-order completion, in-order commit
    cyc(0, 3'b001, 6'd1, 0, 0, 0);
    chk("ooo_no_commit", 32'(commit_valid), 0);
    cyc(0, 3'b010, 6'b000000, 0, 0, 0);
    chk("ooo_commit0", 32'(commit_tag), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("ooo_commit1", 32'(commit_tag), 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("ooo_count", 32'(count), 2);

    // Wrap: allocate 6 with completions trailing behind
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      bit [5:0] ct;
      ct = {2'((i + 1) % 4), 2'((i + 2) % 4), 2'((i + 3) % 4)};
      cyc(1, 3'b111, ct, 0, 0, 0);
      chk("wrap_bound", 32'(count <= 4), 1);
    end

    // Flush tag 1 with an allocation and a completion to a flushed entry
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 3'b001, 6'd2, 1, 2'd1, 0);
    chk("flush_count", 32'(count), 2);
    chk("flush_tail", 32'(alloc_tag), 2);
    cyc(0, 3'b011, 6'b000100, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 3'b001, 6'd2, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("flush_drained", 32'(empty), 1);
    chk("flush_no_tag2", 32'(commit_valid), 0);

    // Head commits while it is also the flush target
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 3'b001, 6'd0, 0, 0, 0);
    chk("hflush_cv", 32'(commit_valid), 1);
    cyc(0, 0, 0, 1, 2'd0, 0);
    chk("hflush_count", 32'(count), 0);
    chk("hflush_empty", 32'(empty), 1);

    // Reset mid-operation with a commit ready and a completion in flight
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 3'b001, 6'd0, 0, 0, 0);
    cyc(1, 3'b001, 6'd1, 0, 0, 1);
    chk("mrst_count", 32'(count), 0);
    chk("mrst_cv", 32'(commit_valid), 0);
    chk("mrst_tag", 32'(alloc_tag), 0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 99) < 65, 3'($urandom), 6'($urandom),
          $urandom_range(0, 99) < 6, 2'($urandom), $urandom_range(0, 199) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
